// File: rtl/ldgm_mem_pkg.sv
// Shared defaults and FSM state type for the matrix-ROM row streamer.
package ldgm_mem_pkg;

  localparam int unsigned LDGM_ADDR_W    = 10;
  localparam int unsigned LDGM_BANK_W    = 350;
  localparam int unsigned LDGM_NUM_BANKS = 3;
  localparam int unsigned LDGM_ROW_W     = LDGM_NUM_BANKS * LDGM_BANK_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } ldgm_state_e;

endpackage

// File: rtl/ldgm_row_fifo.sv
// Small synchronous FIFO for row words; depth need not be a power of two.
module ldgm_row_fifo
  import ldgm_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = LDGM_ROW_W + LDGM_ADDR_W + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_pop;
  logic             do_push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ldgm_mat_row_streamer.sv
// Streams num_rows consecutive matrix rows from banked synchronous ROMs with
// ready/valid backpressure. Define ROW_XOR_ACC_EN to add the xor_acc output.
module ldgm_mat_row_streamer
  import ldgm_mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = LDGM_ADDR_W,
  parameter int unsigned BANK_W    = LDGM_BANK_W,
  parameter int unsigned NUM_BANKS = LDGM_NUM_BANKS,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned FIFO_D    = RD_LAT + 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             base_addr,
  input  logic [ADDR_W:0]               num_rows,
  output logic                          busy,
  output logic                          done,
  output logic                          mem_en,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic [NUM_BANKS*BANK_W-1:0]   mem_dout,
  output logic                          row_valid,
  input  logic                          row_ready,
  output logic [NUM_BANKS*BANK_W-1:0]   row_data,
  output logic [ADDR_W:0]               row_idx
`ifdef ROW_XOR_ACC_EN
  ,
  output logic [NUM_BANKS*BANK_W-1:0]   xor_acc
`endif
);

  localparam int unsigned ROW_W = NUM_BANKS * BANK_W;
  localparam int unsigned FW    = ROW_W + ADDR_W + 1;
  localparam int unsigned CW    = $clog2(FIFO_D + 1);

  ldgm_state_e      state;
  logic [ADDR_W:0]  issue_left;
  logic [ADDR_W:0]  accept_left;
  logic [ADDR_W:0]  push_idx;
  logic [RD_LAT-1:0] rd_pipe;
  logic             push;
  logic             pop;
  logic             f_full;
  logic             f_empty;
  logic [CW-1:0]    f_count;
  logic [FW-1:0]    f_rdata;
  logic [31:0]      outstanding;
  logic             credit_ok;

  assign push      = rd_pipe[RD_LAT-1];
  assign row_valid = !f_empty;
  assign pop       = row_valid && row_ready;
  assign row_data  = f_empty ? '0 : f_rdata[FW-1:ADDR_W+1];
  assign row_idx   = f_empty ? '0 : f_rdata[ADDR_W:0];

  ldgm_row_fifo #(
    .DEPTH (FIFO_D),
    .WIDTH (FW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({mem_dout, push_idx}),
    .pop   (pop),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  // Every read in the ROM pipe or on the bus already owns a FIFO slot; a pop
  // this cycle hands its slot to the next issue.
  always_comb begin
    outstanding = 32'(f_count) + 32'(mem_en);
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      outstanding = outstanding + 32'(rd_pipe[i]);
    end
    credit_ok = outstanding < (32'(FIFO_D) + 32'(pop));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= mem_en;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_en      <= 1'b0;
      mem_addr    <= '0;
      issue_left  <= '0;
      accept_left <= '0;
      push_idx    <= '0;
    end else begin
      done <= 1'b0;
      if (push) push_idx <= push_idx + 1'b1;
      if (pop)  accept_left <= accept_left - 1'b1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            push_idx    <= '0;
            accept_left <= num_rows;
            if (num_rows == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state      <= ST_FETCH;
              mem_en     <= 1'b1;
              mem_addr   <= base_addr;
              issue_left <= num_rows - 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (issue_left == '0) begin
            mem_en <= 1'b0;
            state  <= ST_DRAIN;
          end else if (credit_ok) begin
            mem_en     <= 1'b1;
            mem_addr   <= mem_addr + 1'b1;
            issue_left <= issue_left - 1'b1;
          end else begin
            mem_en <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (pop && accept_left == (ADDR_W+1)'(1)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ROW_XOR_ACC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xor_acc <= '0;
    end else if (start && state == ST_IDLE) begin
      xor_acc <= '0;
    end else if (pop) begin
      xor_acc <= xor_acc ^ row_data;
    end
  end
`endif

  assert property (@(posedge clk) disable iff (!rst_n) !(push && f_full && !pop));

endmodule

// File: tb/tb_ldgm_mat_row_streamer.sv
// Bench: two streamers (RD_LAT=1 and RD_LAT=3) share stimulus; each has its own ROM model.
module tb_ldgm_mat_row_streamer;

  localparam int ADDR_W    = 10;
  localparam int BANK_W    = 40;
  localparam int NUM_BANKS = 3;
  localparam int ROW_W     = NUM_BANKS * BANK_W;
  localparam int DEPTH_A   = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   num_rows;
  logic              row_ready;

  logic              busy [2];
  logic              done [2];
  logic              mem_en [2];
  logic              row_valid [2];
  logic [ADDR_W-1:0] mem_addr [2];
  logic [ROW_W-1:0]  mem_dout [2];
  logic [ROW_W-1:0]  row_data [2];
  logic [ADDR_W:0]   row_idx [2];
`ifdef ROW_XOR_ACC_EN
  logic [ROW_W-1:0]  xor_acc [2];
  logic [ROW_W-1:0]  xor_at_done [2];
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int fdep(input int k);
    return lat(k) + 2;
  endfunction

  function automatic logic [ROW_W-1:0] rom(input int a);
    logic [127:0] w;
    logic [31:0]  x;
    x = 32'(a % DEPTH_A);
    w = {x * 32'h9E3779B1, (x * 32'h85EBCA6B) ^ 32'h0F0F1234, (~x) * 32'hC2B2AE35, x ^ 32'hA5A50000};
    return w[ROW_W-1:0];
  endfunction

  ldgm_mat_row_streamer #(
    .ADDR_W(ADDR_W), .BANK_W(BANK_W), .NUM_BANKS(NUM_BANKS), .RD_LAT(1)
  ) u_lat1 (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .busy(busy[0]), .done(done[0]), .mem_en(mem_en[0]), .mem_addr(mem_addr[0]),
    .mem_dout(mem_dout[0]), .row_valid(row_valid[0]), .row_ready(row_ready),
    .row_data(row_data[0]), .row_idx(row_idx[0])
`ifdef ROW_XOR_ACC_EN
    , .xor_acc(xor_acc[0])
`endif
  );

  ldgm_mat_row_streamer #(
    .ADDR_W(ADDR_W), .BANK_W(BANK_W), .NUM_BANKS(NUM_BANKS), .RD_LAT(3)
  ) u_lat3 (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .busy(busy[1]), .done(done[1]), .mem_en(mem_en[1]), .mem_addr(mem_addr[1]),
    .mem_dout(mem_dout[1]), .row_valid(row_valid[1]), .row_ready(row_ready),
    .row_data(row_data[1]), .row_idx(row_idx[1])
`ifdef ROW_XOR_ACC_EN
    , .xor_acc(xor_acc[1])
`endif
  );

  // ROM models: one-stage and three-stage synchronous read pipes.
  logic [ROW_W-1:0] rp0;
  logic [ROW_W-1:0] rp1 [3];
  always @(posedge clk) begin
    if (mem_en[0]) rp0 <= rom(int'(mem_addr[0]));
    rp1[2] <= rp1[1];
    rp1[1] <= rp1[0];
    if (mem_en[1]) rp1[0] <= rom(int'(mem_addr[1]));
  end
  assign mem_dout[0] = rp0;
  assign mem_dout[1] = rp1[2];

  always @(posedge clk) cyc++;

  logic [ROW_W-1:0]  acc_data [2][$];
  int                acc_idx [2][$];
  int                iss_addr [2][$];
  int                iss_cyc [2][$];
  int                first_valid [2];
  int                last_acc [2];
  int                done_cnt [2];
  int                done_cyc [2];
  int                ovf_err [2];
  int                stable_err [2];
  logic              prev_stall [2];
  logic [ROW_W-1:0]  prev_data [2];
  logic [ADDR_W:0]   prev_idx [2];

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (mem_en[k]) begin
          iss_addr[k].push_back(int'(mem_addr[k]));
          iss_cyc[k].push_back(cyc);
        end
        if (iss_addr[k].size() - acc_data[k].size() > fdep(k)) ovf_err[k]++;
        if (row_valid[k] && first_valid[k] < 0) first_valid[k] = cyc;
        if (prev_stall[k] && (!row_valid[k] || row_data[k] !== prev_data[k] || row_idx[k] !== prev_idx[k]))
          stable_err[k]++;
        prev_stall[k] = row_valid[k] && !row_ready;
        prev_data[k]  = row_data[k];
        prev_idx[k]   = row_idx[k];
        if (row_valid[k] && row_ready) begin
          acc_data[k].push_back(row_data[k]);
          acc_idx[k].push_back(int'(row_idx[k]));
          last_acc[k] = cyc;
        end
        if (done[k]) begin
          done_cnt[k]++;
          done_cyc[k] = cyc;
`ifdef ROW_XOR_ACC_EN
          xor_at_done[k] = xor_acc[k];
`endif
        end
      end
    end
  end

  task automatic clear_mon();
    for (int k = 0; k < 2; k++) begin
      acc_data[k].delete();
      acc_idx[k].delete();
      iss_addr[k].delete();
      iss_cyc[k].delete();
      first_valid[k] = -1;
      last_acc[k]    = -1;
      done_cnt[k]    = 0;
      done_cyc[k]    = -1;
      ovf_err[k]     = 0;
      stable_err[k]  = 0;
      prev_stall[k]  = 1'b0;
    end
  endtask

  // Called at posedge+1; pulses start, applies random ready, waits for both done pulses.
  task automatic drive_burst(input int base, input int num, input int pct, input int poke);
    int n;
    clear_mon();
    base_addr = ADDR_W'(base);
    num_rows  = (ADDR_W+1)'(num);
    start     = 1'b1;
    row_ready = ($urandom_range(99) < pct);
    start_cyc = cyc + 1;
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = ADDR_W'($urandom);
    num_rows  = (ADDR_W+1)'($urandom);
    n = 0;
    while (!(done_cnt[0] > 0 && done_cnt[1] > 0) && n < 3000) begin
      row_ready = ($urandom_range(99) < pct);
      start     = (n == poke);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    checks++;
    if (n >= 3000) begin
      failures++;
      $display("FAIL burst_timeout base=%0d num=%0d cycles=%0d required<3000", base, num, n);
    end
    row_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset(input string tag);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({busy[k], done[k], mem_en[k], row_valid[k]} !== 4'b0000) begin
        failures++;
        $display("FAIL %s_ctrl inst%0d got=%b required=0000", tag, k, {busy[k], done[k], mem_en[k], row_valid[k]});
      end
      checks++;
      if (mem_addr[k] !== '0) begin
        failures++;
        $display("FAIL %s_addr inst%0d got=%h required=0", tag, k, mem_addr[k]);
      end
      checks++;
      if (row_data[k] !== '0 || row_idx[k] !== '0) begin
        failures++;
        $display("FAIL %s_row inst%0d data=%h idx=%0d required=0", tag, k, row_data[k], row_idx[k]);
      end
    end
  endtask

  task automatic test_basic();
    drive_burst(5, 4, 100, -1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (acc_data[k].size() != 4 || iss_addr[k].size() != 4) begin
        failures++;
        $display("FAIL basic_count inst%0d rows=%0d reads=%0d required=4", k, acc_data[k].size(), iss_addr[k].size());
      end
      for (int i = 0; i < 4 && i < acc_data[k].size(); i++) begin
        checks++;
        if (acc_data[k][i] !== rom(5 + i) || acc_idx[k][i] != i) begin
          failures++;
          $display("FAIL basic_row inst%0d i=%0d got=%h/%0d required=%h/%0d", k, i, acc_data[k][i], acc_idx[k][i], rom(5 + i), i);
        end
      end
      for (int i = 0; i < 4 && i < iss_addr[k].size(); i++) begin
        checks++;
        if (iss_addr[k][i] != 5 + i || iss_cyc[k][i] != start_cyc + i) begin
          failures++;
          $display("FAIL basic_issue inst%0d i=%0d addr=%0d cyc=%0d required addr=%0d cyc=%0d", k, i, iss_addr[k][i], iss_cyc[k][i], 5 + i, start_cyc + i);
        end
      end
      checks++;
      if (first_valid[k] != start_cyc + lat(k) + 1) begin
        failures++;
        $display("FAIL basic_latency inst%0d got=%0d required=%0d", k, first_valid[k] - start_cyc, lat(k) + 1);
      end
      checks++;
      if (last_acc[k] != first_valid[k] + 3) begin
        failures++;
        $display("FAIL basic_throughput inst%0d span=%0d required=3", k, last_acc[k] - first_valid[k]);
      end
      checks++;
      if (done_cnt[k] != 1 || done_cyc[k] != last_acc[k] + 1) begin
        failures++;
        $display("FAIL basic_done inst%0d pulses=%0d delay=%0d required 1/1", k, done_cnt[k], done_cyc[k] - last_acc[k]);
      end
    end
  endtask

  task automatic test_wrap();
    drive_burst('h3FE, 4, 100, -1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (acc_data[k].size() != 4 || iss_addr[k].size() != 4) begin
        failures++;
        $display("FAIL wrap_count inst%0d rows=%0d reads=%0d required=4", k, acc_data[k].size(), iss_addr[k].size());
      end
      for (int i = 0; i < 4 && i < acc_data[k].size() && i < iss_addr[k].size(); i++) begin
        checks++;
        if (iss_addr[k][i] != ('h3FE + i) % DEPTH_A || acc_data[k][i] !== rom('h3FE + i) || acc_idx[k][i] != i) begin
          failures++;
          $display("FAIL wrap_row inst%0d i=%0d addr=%h idx=%0d required addr=%h idx=%0d", k, i, iss_addr[k][i], acc_idx[k][i], ('h3FE + i) % DEPTH_A, i);
        end
      end
    end
  endtask

  task automatic test_random_bursts(input string tag, input int nbursts, input int pct_lo, input int poke);
    int base;
    int num;
    for (int b = 0; b < nbursts; b++) begin
      base = $urandom_range(DEPTH_A - 1);
      num  = (nbursts == 1) ? 10 : $urandom_range(24, 1);
      if (poke >= 0) num = 6;
      drive_burst(base, num, $urandom_range(100, pct_lo) == 100 ? 100 : pct_lo, poke);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (acc_data[k].size() != num || iss_addr[k].size() != num || done_cnt[k] != 1) begin
          failures++;
          $display("FAIL %s_count inst%0d rows=%0d reads=%0d dones=%0d required=%0d/%0d/1", tag, k, acc_data[k].size(), iss_addr[k].size(), done_cnt[k], num, num);
        end
        for (int i = 0; i < num && i < acc_data[k].size(); i++) begin
          checks++;
          if (acc_data[k][i] !== rom(base + i) || acc_idx[k][i] != i) begin
            failures++;
            $display("FAIL %s_row inst%0d i=%0d got=%h/%0d required=%h/%0d", tag, k, i, acc_data[k][i], acc_idx[k][i], rom(base + i), i);
          end
        end
        checks++;
        if (ovf_err[k] != 0 || stable_err[k] != 0) begin
          failures++;
          $display("FAIL %s_flow inst%0d overfill=%0d unstable=%0d required=0/0", tag, k, ovf_err[k], stable_err[k]);
        end
      end
    end
  endtask

  task automatic test_zero();
    drive_burst($urandom_range(DEPTH_A - 1), 0, 100, -1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (done_cnt[k] != 1 || done_cyc[k] != start_cyc) begin
        failures++;
        $display("FAIL zero_done inst%0d pulses=%0d at=%0d required 1 at %0d", k, done_cnt[k], done_cyc[k], start_cyc);
      end
      checks++;
      if (iss_addr[k].size() != 0 || acc_data[k].size() != 0 || first_valid[k] >= 0) begin
        failures++;
        $display("FAIL zero_quiet inst%0d reads=%0d rows=%0d valid_at=%0d required none", k, iss_addr[k].size(), acc_data[k].size(), first_valid[k]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    clear_mon();
    base_addr = 'h010;
    num_rows  = 8;
    start     = 1'b1;
    row_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    test_reset("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive_burst(0, 1, 100, -1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (acc_data[k].size() != 1 || iss_addr[k].size() != 1) begin
        failures++;
        $display("FAIL post_reset_count inst%0d rows=%0d reads=%0d required=1", k, acc_data[k].size(), iss_addr[k].size());
      end else begin
        checks++;
        if (acc_data[k][0] !== rom(0) || acc_idx[k][0] != 0) begin
          failures++;
          $display("FAIL post_reset_row inst%0d got=%h/%0d required=%h/0", k, acc_data[k][0], acc_idx[k][0], rom(0));
        end
      end
    end
  endtask

`ifdef ROW_XOR_ACC_EN
  task automatic test_xor_acc();
    int n;
    drive_burst(0, 3, 100, -1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (xor_at_done[k] !== (rom(0) ^ rom(1) ^ rom(2)) || xor_acc[k] !== (rom(0) ^ rom(1) ^ rom(2))) begin
        failures++;
        $display("FAIL xor_final inst%0d at_done=%h now=%h required=%h", k, xor_at_done[k], xor_acc[k], rom(0) ^ rom(1) ^ rom(2));
      end
    end
    clear_mon();
    base_addr = 7;
    num_rows  = 2;
    start     = 1'b1;
    row_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (xor_acc[k] !== '0) begin
        failures++;
        $display("FAIL xor_clear inst%0d got=%h required=0", k, xor_acc[k]);
      end
    end
    row_ready = 1'b1;
    n = 0;
    while (!(done_cnt[0] > 0 && done_cnt[1] > 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (n >= 200 || xor_at_done[k] !== (rom(7) ^ rom(8))) begin
        failures++;
        $display("FAIL xor_second inst%0d got=%h required=%h waited=%0d", k, xor_at_done[k], rom(7) ^ rom(8), n);
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    start     = 1'b0;
    base_addr = '0;
    num_rows  = '0;
    row_ready = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    test_reset("reset_held");
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset("reset_released");
    test_basic();
    test_wrap();
    test_random_bursts("backpressure", 1, 30, -1);
    test_zero();
    test_random_bursts("busy_ignore", 1, 60, 1);
    test_random_bursts("random", 4, 20, -1);
    test_reset_mid_burst();
`ifdef ROW_XOR_ACC_EN
    test_xor_acc();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
